// File: rtl/uart_dbg_bridge.sv
// UART (8N1) command bridge to a 32-bit bus initiator: 'W' addr data / 'R' addr, answered with ACK/NAK (+read data).
// Optional UART_DBG_ALIGN_CHECK_EN: misaligned addresses are NAKed without issuing a bus request.
module uart_dbg_bridge #(
  parameter int unsigned CLK_DIV     = 434,
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] m_address,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wsel,
  output logic        m_valid,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  input  logic        m_error,
  output logic        busy
);

  localparam logic [7:0]  CMD_W       = 8'h57;
  localparam logic [7:0]  CMD_R       = 8'h52;
  localparam logic [7:0]  ACK         = 8'h06;
  localparam logic [7:0]  NAK         = 8'h15;
  localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] TO_LAST     = 16'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP, S_RDATA
  } state_t;

  // receiver
  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev, rx_active, rx_valid, rx_ferr;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bitn;
  logic [7:0]  rx_sh;

  // transmitter
  logic [9:0]  tx_shift;
  logic [3:0]  tx_bits;
  logic [15:0] tx_cnt;
  logic        tx_load_c, tx_done_c;
  logic [7:0]  tx_data_c;

  // parser
  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic        is_write, is_write_n, resp_ack, resp_ack_n, go_bus_c;
  logic [31:0] rdata_q, rdata_n, address_n, wdata_n;
  logic [15:0] to_cnt, to_cnt_n;
  logic [3:0]  wsel_n;
  logic        valid_n;

  assign rx_s      = rx_sync[1];
  assign uart_tx   = tx_shift[0];
  assign tx_done_c = (tx_bits == 4'd1) && (tx_cnt == 16'd0);

  // Start on a falling edge, sample mid-bit: start, 8 data bits LSB first, stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync   <= 2'b11;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_cnt    <= 16'd0;
      rx_bitn   <= 4'd0;
      rx_sh     <= 8'h00;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (rx_prev && !rx_s) begin
          rx_active <= 1'b1;
          rx_cnt    <= HALF_RELOAD;
          rx_bitn   <= 4'd0;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt  <= BIT_RELOAD;
        rx_bitn <= rx_bitn + 4'd1;
        if (rx_bitn == 4'd0) begin
          if (rx_s) rx_active <= 1'b0;
        end else if (rx_bitn <= 4'd8) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
        end else begin
          rx_active <= 1'b0;
          rx_valid  <= rx_s;
          rx_ferr   <= !rx_s;
        end
      end
    end
  end

  // A load on the final stop-bit cycle chains bytes with no idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '1;
      tx_bits  <= 4'd0;
      tx_cnt   <= 16'd0;
    end else if (tx_load_c) begin
      tx_shift <= {1'b1, tx_data_c, 1'b0};
      tx_bits  <= 4'd10;
      tx_cnt   <= BIT_RELOAD;
    end else if (tx_bits != 4'd0) begin
      if (tx_cnt == 16'd0) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bits  <= tx_bits - 4'd1;
        tx_cnt   <= BIT_RELOAD;
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      is_write  <= 1'b0;
      resp_ack  <= 1'b0;
      rdata_q   <= 32'h0;
      to_cnt    <= 16'd0;
      m_address <= 32'h0;
      m_wdata   <= 32'h0;
      m_wsel    <= 4'h0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      is_write  <= is_write_n;
      resp_ack  <= resp_ack_n;
      rdata_q   <= rdata_n;
      to_cnt    <= to_cnt_n;
      m_address <= address_n;
      m_wdata   <= wdata_n;
      m_wsel    <= wsel_n;
      m_valid   <= valid_n;
      busy      <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    is_write_n = is_write;
    resp_ack_n = resp_ack;
    rdata_n    = rdata_q;
    to_cnt_n   = to_cnt;
    address_n  = m_address;
    wdata_n    = m_wdata;
    wsel_n     = m_wsel;
    valid_n    = m_valid;
    tx_load_c  = 1'b0;
    tx_data_c  = 8'h00;
    go_bus_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_sh == CMD_W || rx_sh == CMD_R) begin
            state_n    = S_ADDR;
            idx_n      = 2'd0;
            is_write_n = (rx_sh == CMD_W);
          end else begin
            tx_load_c  = 1'b1;
            tx_data_c  = NAK;
            resp_ack_n = 1'b0;
            state_n    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_ferr) begin
          state_n = S_IDLE;
        end else if (rx_valid) begin
          address_n[{idx, 3'b000} +: 8] = rx_sh;
          idx_n = idx + 2'd1;
          if (idx == 2'd3) begin
            if (is_write) state_n = S_DATA;
            else          go_bus_c = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_n = S_IDLE;
        end else if (rx_valid) begin
          wdata_n[{idx, 3'b000} +: 8] = rx_sh;
          idx_n = idx + 2'd1;
          if (idx == 2'd3) go_bus_c = 1'b1;
        end
      end
      S_BUS: begin
        to_cnt_n = to_cnt + 16'd1;
        // ready wins over a timeout landing on the same cycle
        if (m_ready || to_cnt == TO_LAST) begin
          valid_n    = 1'b0;
          rdata_n    = m_ready ? m_rdata : rdata_q;
          resp_ack_n = m_ready && !m_error;
          tx_load_c  = 1'b1;
          tx_data_c  = (m_ready && !m_error) ? ACK : NAK;
          state_n    = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_done_c) begin
          if (resp_ack && !is_write) begin
            tx_load_c = 1'b1;
            tx_data_c = rdata_q[7:0];
            idx_n     = 2'd1;
            state_n   = S_RDATA;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_RDATA: begin
        // idx is the next byte to send; wraps to 0 once byte 3 is loaded
        if (tx_done_c) begin
          if (idx == 2'd0) begin
            state_n = S_IDLE;
          end else begin
            tx_load_c = 1'b1;
            tx_data_c = rdata_q[{idx, 3'b000} +: 8];
            idx_n     = idx + 2'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (go_bus_c) begin
`ifdef UART_DBG_ALIGN_CHECK_EN
      if (address_n[1:0] != 2'b00) begin
        tx_load_c  = 1'b1;
        tx_data_c  = NAK;
        resp_ack_n = 1'b0;
        state_n    = S_RESP;
      end else
`endif
      begin
        state_n  = S_BUS;
        valid_n  = 1'b1;
        to_cnt_n = 16'd0;
        wsel_n   = is_write ? 4'hF : 4'h0;
      end
    end
  end

endmodule
